// File: rtl/i2s_rx_fifo_if.sv
// i2s_rx_fifo_if: FIFO drain and status bus between the I2S receiver and its bus wrapper
interface i2s_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic rd_en;
  logic clr_ovr;
  logic empty;
  logic full;
  logic overrun;
  logic [31:0] rd_data;
  logic [DEPTH_LOG2:0] level;
  modport master (output rd_en, clr_ovr, input rd_data, empty, full, level, overrun);
  modport slave (input rd_en, clr_ovr, output rd_data, empty, full, level, overrun);
endinterface

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: I2S master receiver capturing one channel into a sign-extended word FIFO
module i2s_rx_fifo #(
  parameter int CLK_DIV = 4,
  parameter int SAMPLE_BITS = 24,
  parameter int CHANNEL = 0,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic en,
  input  logic I2S_in,
  output logic i2s_clk,
  output logic ws,
  i2s_rx_fifo_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [5:0] FIRST = 6'(32 * CHANNEL + 1);
  localparam logic [5:0] LAST = 6'(32 * CHANNEL + SAMPLE_BITS);
  logic run_q, run_d;
  logic [DW-1:0] div_q, div_d;
  logic clk_q, clk_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic push_q, push_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ovr_q, ovr_d;
  logic [31:0] mem_q [DEPTH];
  logic tick, fall, cap, empty, full, pop, wr, drop;
  logic [31:0] word;
  always_comb begin
    tick = run_q && div_q == DW'(CLK_DIV - 1);
    fall = tick && clk_q;
    cap = fall && bit_cnt_q >= FIRST && bit_cnt_q <= LAST;
    run_d = en;
    div_d = (!en || !run_q || tick) ? '0 : div_q + DW'(1);
    clk_d = en && (tick ? !clk_q : clk_q);
    bit_cnt_d = !en ? '0 : fall ? bit_cnt_q + 6'd1 : bit_cnt_q;
    shift_d = !en ? '0 : cap ? SAMPLE_BITS'({shift_q, I2S_in}) : shift_q;
    push_d = en && fall && bit_cnt_q == LAST;
    word = {{(32 - SAMPLE_BITS){shift_q[SAMPLE_BITS-1]}}, shift_q};
    empty = wr_ptr_q == rd_ptr_q;
    full = wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2] &&
           wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0];
    pop = bus.rd_en && !empty;
    wr = push_q && (!full || bus.rd_en);
    drop = push_q && full && !bus.rd_en;
    wr_ptr_d = wr_ptr_q + PW'(wr);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovr_d = drop || (ovr_q && !bus.clr_ovr);
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      run_q <= 1'b0;
      div_q <= '0;
      clk_q <= 1'b0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      push_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      clk_q <= clk_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      push_q <= push_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q <= ovr_d;
    end
  end
  always_ff @(posedge HCLK) begin
    if (wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= word;
  end
  assign i2s_clk = clk_q;
  assign ws = bit_cnt_q[5];
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.level = wr_ptr_q - rd_ptr_q;
  assign bus.overrun = ovr_q;
  assign bus.rd_data = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
endmodule

// File: tb/tb_i2s_rx_fifo.sv
// tb_i2s_rx_fifo: left and right receivers against a frame-level model of the I2S stream and FIFO
module tb_i2s_rx_fifo;
  localparam int CD = 4;
  localparam int SB = 24;
  localparam int DL = 3;
  localparam int DEPTH = 1 << DL;
  localparam int FRAME = 128 * CD;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic din = 1'b0;
  logic rd_en = 1'b0;
  logic clr_ovr = 1'b0;
  logic mon = 1'b0;
  logic [1:0] bclk, wsel;
  i2s_rx_fifo_if #(.DEPTH_LOG2(DL)) b0 ();
  i2s_rx_fifo_if #(.DEPTH_LOG2(DL)) b1 ();
  assign b0.rd_en = rd_en;
  assign b1.rd_en = rd_en;
  assign b0.clr_ovr = clr_ovr;
  assign b1.clr_ovr = clr_ovr;
  always #5 clk = ~clk;
  i2s_rx_fifo #(.CLK_DIV(CD), .SAMPLE_BITS(SB), .CHANNEL(0), .DEPTH_LOG2(DL)) d0 (
    .HCLK(clk), .HRESET(rst), .en(en), .I2S_in(din), .i2s_clk(bclk[0]), .ws(wsel[0]), .bus(b0));
  i2s_rx_fifo #(.CLK_DIV(CD), .SAMPLE_BITS(SB), .CHANNEL(1), .DEPTH_LOG2(DL)) d1 (
    .HCLK(clk), .HRESET(rst), .en(en), .I2S_in(din), .i2s_clk(bclk[1]), .ws(wsel[1]), .bus(b1));
  int checks = 0;
  int fails = 0;
  int e = -1;
  int fbase = 0;
  logic started = 1'b0;
  logic [SB-1:0] smp [64][2];
  logic [31:0] mq [2][DEPTH];
  int mn [2];
  logic movr [2];
  logic mpend [2];
  logic [31:0] mword [2];
  logic mdrop;
  int dbc, dk;
  function automatic logic [31:0] sx(logic [SB-1:0] v);
    return {{(32 - SB){v[SB-1]}}, v};
  endfunction
  function automatic int push_edge(int c);
    return 2 * CD * (32 * c + SB + 1);
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask
  initial begin
    mn[0] = 0; mn[1] = 0; movr[0] = 0; movr[1] = 0; mpend[0] = 0; mpend[1] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = -1;
        for (int c = 0; c < 2; c++) begin
          mn[c] = 0; movr[c] = 0; mpend[c] = 0;
        end
      end else begin
        for (int c = 0; c < 2; c++) begin
          mdrop = 1'b0;
          if (rd_en && mn[c] > 0) begin
            for (int i = 0; i < DEPTH - 1; i++) mq[c][i] = mq[c][i+1];
            mn[c]--;
          end
          if (mpend[c]) begin
            if (mn[c] < DEPTH) begin
              mq[c][mn[c]] = mword[c];
              mn[c]++;
            end else mdrop = 1'b1;
          end
          if (mdrop) movr[c] = 1'b1;
          else if (clr_ovr) movr[c] = 1'b0;
        end
        if (!en) e = -1;
        else begin
          if (e < 0 && started) fbase += 16;
          started = 1'b1;
          e++;
        end
        for (int c = 0; c < 2; c++) begin
          mpend[c] = en && e >= 0 && (e % FRAME) == push_edge(c);
          mword[c] = sx(smp[(fbase + e / FRAME) % 64][c]);
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (e < 0) din = 1'($urandom);
    else begin
      dbc = (e / (2 * CD)) % 64;
      dk = dbc % 32;
      din = (dk >= 1 && dk <= SB) ? smp[(fbase + e / FRAME) % 64][dbc / 32][SB - dk] : 1'($urandom);
    end
  end
  task automatic cmp(int c, logic bk, logic w, logic em, logic fu, logic [DL:0] lv, logic ov, logic [31:0] rd);
    chk($sformatf("d%0d_i2s_clk", c), 32'(bk), e < 0 ? 0 : (e / CD) % 2);
    chk($sformatf("d%0d_ws", c), 32'(w), e < 0 ? 0 : 32'(((e / (2 * CD)) % 64) >= 32));
    chk($sformatf("d%0d_empty", c), 32'(em), 32'(mn[c] == 0));
    chk($sformatf("d%0d_full", c), 32'(fu), 32'(mn[c] == DEPTH));
    chk($sformatf("d%0d_level", c), 32'(lv), 32'(mn[c]));
    chk($sformatf("d%0d_overrun", c), 32'(ov), 32'(movr[c]));
    chk($sformatf("d%0d_rd_data", c), rd, mn[c] == 0 ? 32'h0 : mq[c][0]);
  endtask
  initial forever begin
    @(negedge clk);
    if (mon) begin
      cmp(0, bclk[0], wsel[0], b0.empty, b0.full, b0.level, b0.overrun, b0.rd_data);
      cmp(1, bclk[1], wsel[1], b1.empty, b1.full, b1.level, b1.overrun, b1.rd_data);
    end
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic upto(int n);
    int g = 0;
    while (e < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (e < n) chk("wait_edge", 32'(e), 32'(n));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 64; i++) begin
      smp[i][0] = SB'($urandom);
      smp[i][1] = SB'($urandom);
    end
    smp[0][0] = 24'h800001;
    smp[0][1] = 24'h123456;
    step(3);
    mon = 1'b1;
    chk("rst_empty", 32'(b0.empty), 1);
    chk("rst_full", 32'(b0.full), 0);
    chk("rst_level", 32'(b0.level), 0);
    chk("rst_overrun", 32'(b0.overrun), 0);
    chk("rst_rd_data", b0.rd_data, 0);
    chk("rst_i2s_clk", 32'(bclk[0]), 0);
    rst = 1'b0;
    en = 1'b1;
    upto(3);
    chk("bclk_e3", 32'(bclk[0]), 0);
    upto(4);
    chk("bclk_e4", 32'(bclk[0]), 1);
    upto(8);
    chk("bclk_e8", 32'(bclk[0]), 0);
    upto(200);
    chk("empty_e200", 32'(b0.empty), 1);
    upto(201);
    chk("level_e201", 32'(b0.level), 1);
    chk("left_word", b0.rd_data, 32'hFF800001);
    upto(255);
    chk("ws_e255", 32'(wsel[1]), 0);
    upto(256);
    chk("ws_e256", 32'(wsel[1]), 1);
    upto(456);
    chk("right_empty_e456", 32'(b1.empty), 1);
    upto(457);
    chk("right_word", b1.rd_data, 32'h00123456);
    chk("left_ignores_right", 32'(b0.level), 1);
    upto(7 * FRAME + 201);
    chk("full_frame8", 32'(b0.full), 1);
    chk("no_ovr_frame8", 32'(b0.overrun), 0);
    upto(8 * FRAME + 201);
    chk("ovr_frame9", 32'(b0.overrun), 1);
    chk("level_frame9", 32'(b0.level), 8);
    chk("head_frame1", b0.rd_data, 32'hFF800001);
    upto(8 * FRAME + 457);
    chk("ovr_right", 32'(b1.overrun), 1);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk("clr_ovr0", 32'(b0.overrun), 0);
    chk("clr_ovr1", 32'(b1.overrun), 0);
    upto(9 * FRAME + 200);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("full_rw_level", 32'(b0.level), 8);
    chk("full_rw_ovr", 32'(b0.overrun), 0);
    chk("full_rw_head", b0.rd_data, sx(smp[1][0]));
    rd_en = 1'b1;
    step(10);
    rd_en = 1'b0;
    chk("drained_empty", 32'(b0.empty), 1);
    chk("drained_rd_data", b0.rd_data, 0);
    en = 1'b0;
    step(5);
    chk("idle_bclk", 32'(bclk[0]), 0);
    en = 1'b1;
    upto(100);
    en = 1'b0;
    step(3);
    chk("abort_bclk", 32'(bclk[0]), 0);
    chk("abort_ws", 32'(wsel[1]), 0);
    step(300);
    chk("abort_no_push", 32'(b0.level), 0);
    smp[(fbase + 16) % 64][0] = 24'h7FFFFF;
    en = 1'b1;
    upto(201);
    chk("fresh_word", b0.rd_data, 32'h007FFFFF);
    for (int i = 0; i < 6000; i++) begin
      rd_en = ($urandom_range(0, 699) == 0);
      clr_ovr = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2999) == 0) begin
        en = 1'b0;
        step(int'($urandom_range(1, 40)));
        en = 1'b1;
      end
      step(1);
    end
    rd_en = 1'b1;
    clr_ovr = 1'b0;
    en = 1'b0;
    step(10);
    rd_en = 1'b0;
    en = 1'b1;
    upto(2 * FRAME + 202);
    chk("three_queued", 32'(b0.level), 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_empty", 32'(b0.empty), 1);
    chk("rst_mid_level", 32'(b0.level), 0);
    chk("rst_mid_rd_data", b0.rd_data, 0);
    chk("rst_mid_bclk", 32'(bclk[0]), 0);
    step(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
